// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a 4-phase req/ack bundled-data crossing.
// Launches a held word with a registered req_a and waits on a synchronized ack_b.
module cdc_handshake_tx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_a,
    input  logic              rst_a,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              req_a,
    output logic [DATA_W-1:0] data_a,
    input  logic              ack_b,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StReq, StDrop} state_t;

    state_t                 r_state;
    state_t                 w_state_d;
    logic                   r_req;
    logic                   w_req_d;
    logic [DATA_W-1:0]      r_data;
    logic [DATA_W-1:0]      w_data_d;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_ack_s;
    logic                   w_ready;

    // Plain shift chain; only the last stage is ever observed by the FSM.
    always_ff @(posedge clk_a or posedge rst_a) begin
        if (rst_a) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ack_b};
        end
    end

    assign w_ack_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_a or posedge rst_a) begin
        if (rst_a) begin
            r_state <= StIdle;
            r_req   <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_req   <= w_req_d;
            r_data  <= w_data_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_req_d   = r_req;
        w_data_d  = r_data;
        w_ready   = 1'b0;
        unique case (r_state)
            StIdle: begin
                // A stale ack from a previous transfer blocks new requests.
                w_ready = !w_ack_s;
                if (in_valid && w_ready) begin
                    w_data_d  = in_data;
                    w_req_d   = 1'b1;
                    w_state_d = StReq;
                end
            end
            StReq: begin
                if (w_ack_s) begin
                    w_req_d   = 1'b0;
                    w_state_d = StDrop;
                end
            end
            StDrop: begin
                if (!w_ack_s) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_req_d   = 1'b0;
            end
        endcase
    end

    assign in_ready = w_ready;
    assign req_a    = r_req;
    assign data_a   = r_data;
    assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a clk_b echo receiver model.
// Exact sync timing is checked with a manually driven ack; ratio runs use the echo.
`timescale 1ns/1ps
module tb_cdc_handshake_tx;

    logic       clk_a = 1'b0;
    logic       clk_b = 1'b0;
    logic       rst_a = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       req_a;
    logic [7:0] data_a;
    logic       ack_b;
    logic       busy;

    logic       man_ack = 1'b0;
    logic       echo_en = 1'b0;
    logic [2:0] r_rs;
    int         ha = 5;
    int         hb = 4;
    int         checks = 0;
    int         errors = 0;
    int         req_rises = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];

    cdc_handshake_tx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_a    (clk_a),
        .rst_a    (rst_a),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .req_a    (req_a),
        .data_a   (data_a),
        .ack_b    (ack_b),
        .busy     (busy)
    );

    always begin
        #(ha) clk_a = ~clk_a;
    end

    always begin
        #(hb) clk_b = ~clk_b;
    end

    // Receiver: 2-flop sync of req_a, one more flop of echo delay, capture on synced rise.
    always @(posedge clk_b or posedge rst_a) begin
        if (rst_a) begin
            r_rs <= 3'b000;
        end else begin
            r_rs <= {r_rs[1:0], req_a};
            if (r_rs[1] && !r_rs[2]) rxq.push_back(data_a);
        end
    end

    assign ack_b = echo_en ? r_rs[2] : man_ack;

    always @(posedge req_a) req_rises++;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_a);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 500) begin
            step();
            n++;
        end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            step();
            n++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    task automatic send(input logic [7:0] w);
        in_data  = w;
        in_valid = 1'b1;
        wait_ready();
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset values and release.
        step(3);
        chk("rst_req", {31'd0, req_a}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", {24'd0, data_a}, 32'd0);
        rst_a = 1'b0;
        chk("rel_ready", {31'd0, in_ready}, 32'd1);

        // Manual ack: exact latency through the 2-stage chain.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
        chk("acc_req", {31'd0, req_a}, 32'd1);
        chk("acc_data", {24'd0, data_a}, 32'hA5);
        chk("acc_busy", {31'd0, busy}, 32'd1);
        chk("acc_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        step(2);
        chk("bp_req_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_req_data", {24'd0, data_a}, 32'hA5);
        chk("bp_req_held", {31'd0, req_a}, 32'd1);
        in_valid = 1'b0;
        man_ack  = 1'b1;
        step();
        chk("ack_e0_req", {31'd0, req_a}, 32'd1);
        step();
        chk("ack_e1_req", {31'd0, req_a}, 32'd1);
        step();
        chk("ack_e2_req", {31'd0, req_a}, 32'd0);
        chk("drop_busy", {31'd0, busy}, 32'd1);
        chk("drop_data", {24'd0, data_a}, 32'hA5);
        in_valid = 1'b1;
        step(2);
        chk("bp_drop_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_drop_data", {24'd0, data_a}, 32'hA5);
        chk("bp_drop_req", {31'd0, req_a}, 32'd0);
        in_valid = 1'b0;
        man_ack  = 1'b0;
        step();
        chk("fall_e0_busy", {31'd0, busy}, 32'd1);
        step();
        chk("fall_e1_busy", {31'd0, busy}, 32'd1);
        chk("fall_e1_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("fall_e2_busy", {31'd0, busy}, 32'd0);
        chk("fall_e2_ready", {31'd0, in_ready}, 32'd1);
        chk("fall_e2_data", {24'd0, data_a}, 32'hA5);

        // Reset mid-REQ acts asynchronously.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        step();
        in_valid = 1'b0;
        chk("mid_req", {31'd0, req_a}, 32'd1);
        rst_a = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, req_a}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_data", {24'd0, data_a}, 32'd0);
        step();
        rst_a = 1'b0;
        chk("mid_rel_ready", {31'd0, in_ready}, 32'd1);

        // Stale ack in IDLE blocks acceptance.
        man_ack = 1'b1;
        step();
        chk("stale_e0_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("stale_e1_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        step(3);
        chk("stale_busy", {31'd0, busy}, 32'd0);
        chk("stale_req", {31'd0, req_a}, 32'd0);
        chk("stale_data", {24'd0, data_a}, 32'd0);
        in_valid = 1'b0;
        man_ack  = 1'b0;
        step();
        chk("unstale_e0_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("unstale_e1_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back with echo receiver.
        echo_en   = 1'b1;
        rxq.delete();
        req_rises = 0;
        for (int w = 1; w <= 4; w++) send(8'(w));
        wait_idle();
        chk("b2b_pulses", req_rises, 32'd4);
        chk("b2b_count", rxq.size(), 32'd4);
        for (int i = 0; i < 4 && i < rxq.size(); i++) begin
            chk("b2b_word", {24'd0, rxq[i]}, i + 1);
        end

        // Clock ratio runs, 1000 words in total.
        for (int r = 0; r < 3; r++) begin
            int nw;
            case (r)
                0: begin ha = 5;  hb = 15; end
                1: begin ha = 15; hb = 5;  end
                default: begin ha = 7; hb = 5; end
            endcase
            nw = (r == 2) ? 334 : 333;
            step(2);
            rxq.delete();
            expq.delete();
            for (int k = 0; k < nw; k++) begin
                logic [7:0] w;
                w = 8'($urandom);
                step($urandom_range(0, 2));
                expq.push_back(w);
                send(w);
            end
            wait_idle();
            step(4);
            chk("ratio_count", rxq.size(), expq.size());
            for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
                chk("ratio_word", {24'd0, rxq[i]}, {24'd0, expq[i]});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
